// File: rtl/sdp_wdma_pkg.sv
// sdp_wdma_pkg: shared constants, wide-word layout and bit-count helper for the SDP write splitter.
package sdp_wdma_pkg;
    localparam int SDP_DW = 256;
    localparam int SDP_WDMA_RATIO = 4;

    typedef struct packed {
        logic [SDP_WDMA_RATIO-1:0]             mask;
        logic [SDP_WDMA_RATIO-1:0][SDP_DW-1:0] seg;
    } wide_word_t;

    function automatic int unsigned one_cnt(input logic [31:0] v);
        int unsigned n = 0;
        for (int i = 0; i < 32; i++) n += 32'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/nv_nvdla_sdp_wdma_lsb_sel.sv
// nv_nvdla_sdp_wdma_lsb_sel: lowest-set-bit priority encoder that also returns the mask with that bit cleared.
module nv_nvdla_sdp_wdma_lsb_sel #(
    parameter int RATIO = 4,
    parameter int SW = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic [RATIO-1:0] mask,
    output logic [SW-1:0]    sel,
    output logic [RATIO-1:0] mask_clr
);
    always_comb begin
        sel = '0;
        for (int i = RATIO - 1; i >= 0; i--) if (mask[i]) sel = SW'(i);
    end

    assign mask_clr = mask & (mask - RATIO'(1));
endmodule

// File: rtl/nv_nvdla_sdp_wdma_split.sv
// nv_nvdla_sdp_wdma_split: splits one wide masked word into one narrow beat per set mask bit, lowest first.
module nv_nvdla_sdp_wdma_split
    import sdp_wdma_pkg::*;
#(
    parameter int DW = SDP_DW,
    parameter int RATIO = SDP_WDMA_RATIO
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rstn,
    input  logic                      inp_pvld,
    output logic                      inp_prdy,
    input  logic [RATIO*DW+RATIO-1:0] inp_data,
    input  logic                      inp_end,
    output logic                      out_pvld,
    input  logic                      out_prdy,
    output logic [DW:0]               out_data,
    output logic                      out_end
);
    localparam int SW = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic                      hold_vld, hold_end, hold_zero;
    logic [RATIO-1:0]          hold_mask, mask_clr, in_mask;
    logic [RATIO-1:0][DW-1:0]  hold_data;
    logic [SW-1:0]             sel;
    logic                      last, inp_acc, out_acc;

    assign in_mask = inp_data[RATIO*DW +: RATIO];

    nv_nvdla_sdp_wdma_lsb_sel #(.RATIO(RATIO), .SW(SW)) u_lsb_sel (
        .mask     (hold_mask),
        .sel      (sel),
        .mask_clr (mask_clr)
    );

    // An all-zero end word still owes one beat so the surface end marker survives.
    assign last     = hold_zero | (one_cnt(32'(hold_mask)) == 1);
    assign out_pvld = hold_vld;
    assign out_end  = hold_vld & last & hold_end;
    assign out_data = {hold_vld & ~hold_zero, hold_data[sel]};
    assign out_acc  = out_pvld & out_prdy;
    assign inp_prdy = ~hold_vld | (out_acc & last);
    assign inp_acc  = inp_pvld & inp_prdy;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            hold_vld  <= 1'b0;
            hold_mask <= '0;
            hold_end  <= 1'b0;
            hold_zero <= 1'b0;
        end else if (inp_acc) begin
            hold_mask <= in_mask;
            hold_end  <= inp_end;
            hold_zero <= (in_mask == '0);
            hold_vld  <= (in_mask != '0) | inp_end;
        end else if (out_acc) begin
            if (last) hold_vld <= 1'b0;
            else hold_mask <= mask_clr;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (inp_acc) hold_data <= inp_data[RATIO*DW-1:0];
    end
endmodule

// File: tb/tb_nv_nvdla_sdp_wdma_split.sv
// tb_nv_nvdla_sdp_wdma_split: randomized and directed checks of the splitter against a beat-queue model.
module tb_nv_nvdla_sdp_wdma_split;
    import sdp_wdma_pkg::*;

    typedef struct {
        logic [256:0] d;
        logic         e;
    } beat_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           inp_pvld = 1'b0;
    logic           inp_prdy;
    logic [1027:0]  inp_data = '0;
    logic           inp_end = 1'b0;
    logic           out_pvld;
    logic           out_prdy = 1'b1;
    logic [256:0]   out_data;
    logic           out_end;

    int             n_chk = 0;
    int             n_err = 0;
    int             mode = 0;
    int             cyc = 0;
    beat_t          q[$];
    wide_word_t     cur_w;
    logic           cur_end;

    nv_nvdla_sdp_wdma_split dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .inp_pvld        (inp_pvld),
        .inp_prdy        (inp_prdy),
        .inp_data        (inp_data),
        .inp_end         (inp_end),
        .out_pvld        (out_pvld),
        .out_prdy        (out_prdy),
        .out_data        (out_data),
        .out_end         (out_end)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [259:0] got, input logic [259:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic new_word(input logic [3:0] m, input logic e);
        for (int i = 0; i < 4; i++)
            cur_w.seg[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                            $urandom(), $urandom(), $urandom(), $urandom()};
        cur_w.mask = m;
        cur_end = e;
    endtask

    // Model: an accepted word contributes one beat per set mask bit in ascending order;
    // an all-zero word contributes nothing unless it ends the surface.
    task automatic push_word();
        beat_t b;
        for (int i = 0; i < 4; i++)
            if (cur_w.mask[i]) begin
                b.d = {1'b1, cur_w.seg[i]};
                b.e = cur_end && ((cur_w.mask >> (i + 1)) == 4'h0);
                q.push_back(b);
            end
        if (cur_w.mask == 4'h0 && cur_end) begin
            b.d = {1'b0, cur_w.seg[0]};
            b.e = 1'b1;
            q.push_back(b);
        end
    endtask

    task automatic step(input logic pv, output logic acc);
        logic exp_rdy;
        @(negedge clk);
        cyc++;
        inp_pvld = pv;
        inp_data = cur_w;
        inp_end  = cur_end;
        out_prdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : ($urandom_range(3) != 0);
        #1;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && out_prdy);
        chk("out_pvld", out_pvld, q.size() != 0);
        chk("inp_prdy", inp_prdy, exp_rdy);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_end", out_end, q[0].e);
            if (out_pvld && out_prdy) void'(q.pop_front());
        end
        acc = pv && inp_prdy;
        if (acc) push_word();
    endtask

    task automatic send(input logic [3:0] m, input logic e);
        logic acc = 1'b0;
        new_word(m, e);
        for (int k = 0; k < 50 && !acc; k++) step(1'b1, acc);
        if (!acc) chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain(input int n);
        logic acc;
        repeat (n) step(1'b0, acc);
    endtask

    initial begin
        logic acc;
        new_word(4'h0, 1'b0);
        #1;
        chk("rst_out_pvld", out_pvld, 1'b0);
        chk("rst_inp_prdy", inp_prdy, 1'b1);
        chk("rst_out_end", out_end, 1'b0);
        chk("rst_out_hi", out_data[256], 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        send(4'hF, 1'b0); drain(6);
        send(4'h3, 1'b0); send(4'h7, 1'b1); drain(8);
        send(4'hA, 1'b0); drain(4);
        send(4'h0, 1'b0); drain(3);
        send(4'h0, 1'b1); drain(3);
        mode = 1;
        send(4'hF, 1'b0); drain(15);
        mode = 0;

        send(4'hF, 1'b1); drain(2);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_out_pvld", out_pvld, 1'b0);
        chk("mid_rst_inp_prdy", inp_prdy, 1'b1);
        chk("mid_rst_out_end", out_end, 1'b0);
        q.delete();
        @(negedge clk);
        rstn = 1'b1;
        send(4'hF, 1'b1); drain(6);

        mode = 2;
        new_word(4'($urandom()), $urandom_range(3) == 0);
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(1) == 1, acc);
            if (acc) new_word(4'($urandom()), $urandom_range(3) == 0);
        end
        mode = 0;
        drain(6);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
